// File: rtl/td4_seq_if.sv
// Bus bundle between the TD4 sequencer and its datapath/ROM.
// master = sequencer side, slave = datapath/ROM side.
// Optional macro TD4_ILLEGAL_HALT_EN adds the trap signal.
interface td4_seq_if #(
  parameter int unsigned CNT_W = 8
);
  logic             run;
  logic             step;
  logic [7:0]       instr;
  logic             alu_cout;
  logic [3:0]       pc;
  logic [1:0]       sel;
  logic [3:0]       imm;
  logic             ld_a;
  logic             ld_b;
  logic             ld_out;
  logic             carry;
  logic             busy;
  logic [CNT_W-1:0] retired;

`ifdef TD4_ILLEGAL_HALT_EN
  logic             trap;

  modport master (
    input  run, step, instr, alu_cout,
    output pc, sel, imm, ld_a, ld_b, ld_out, carry, busy, retired, trap
  );

  modport slave (
    output run, step, instr, alu_cout,
    input  pc, sel, imm, ld_a, ld_b, ld_out, carry, busy, retired, trap
  );
`else
  modport master (
    input  run, step, instr, alu_cout,
    output pc, sel, imm, ld_a, ld_b, ld_out, carry, busy, retired
  );

  modport slave (
    output run, step, instr, alu_cout,
    input  pc, sel, imm, ld_a, ld_b, ld_out, carry, busy, retired
  );
`endif
endinterface

// File: rtl/td4_seq.sv
// TD4 instruction sequencer / control unit.
// Owns pc, carry, IR and the retired counter; fetches from the program ROM,
// decodes, and drives ALU source select, immediate and register-load strobes.
// Optional macro TD4_ILLEGAL_HALT_EN: undefined opcodes enter a sticky TRAP
// state instead of executing as NOPs.
module td4_seq #(
  parameter int unsigned ROM_LAT = 1,  // cycles from pc change to valid instr, >= 1
  parameter int unsigned CNT_W   = 8
) (
  input logic       clk,
  input logic       rst,
  td4_seq_if.master bus
);

  localparam int unsigned FetchW = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
  localparam logic [FetchW-1:0] FetchLast = FetchW'(ROM_LAT - 1);

  // Load strobe mask, ordered {ld_a, ld_b, ld_out}
  localparam logic [2:0] LdA   = 3'b100;
  localparam logic [2:0] LdB   = 3'b010;
  localparam logic [2:0] LdOut = 3'b001;

  typedef enum logic [1:0] {
    StHalt,
    StFetch,
    StExec,
    StTrap
  } state_e;

  state_e           state_q, state_d;
  logic [FetchW-1:0] fcnt_q, fcnt_d;
  logic [3:0]       pc_q, pc_d;
  logic             carry_q, carry_d;
  logic [7:0]       ir_q, ir_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  logic [3:0] op;
  logic [1:0] dec_sel;
  logic [2:0] dec_ld;
  logic       is_alu;
  logic       is_jnc;
  logic       is_jmp;
  logic [2:0] ld;

  assign op = ir_q[7:4];

  // Opcode decode: ALU source, target register, and instruction class
  always_comb begin
    dec_sel = 2'b11;
    dec_ld  = 3'b000;
    is_alu  = 1'b0;
    is_jnc  = 1'b0;
    is_jmp  = 1'b0;
    case (op)
      4'h0: begin dec_sel = 2'b00; dec_ld = LdA;   is_alu = 1'b1; end
      4'h1: begin dec_sel = 2'b01; dec_ld = LdA;   is_alu = 1'b1; end
      4'h2: begin dec_sel = 2'b10; dec_ld = LdA;   is_alu = 1'b1; end
      4'h3: begin dec_sel = 2'b11; dec_ld = LdA;   is_alu = 1'b1; end
      4'h4: begin dec_sel = 2'b00; dec_ld = LdB;   is_alu = 1'b1; end
      4'h5: begin dec_sel = 2'b01; dec_ld = LdB;   is_alu = 1'b1; end
      4'h6: begin dec_sel = 2'b10; dec_ld = LdB;   is_alu = 1'b1; end
      4'h7: begin dec_sel = 2'b11; dec_ld = LdB;   is_alu = 1'b1; end
      4'h9: begin dec_sel = 2'b01; dec_ld = LdOut; is_alu = 1'b1; end
      4'hB: begin dec_sel = 2'b11; dec_ld = LdOut; is_alu = 1'b1; end
      4'hE: is_jnc = 1'b1;
      4'hF: is_jmp = 1'b1;
      default: ;  // 8, A, C, D: undefined
    endcase
  end

`ifdef TD4_ILLEGAL_HALT_EN
  logic illegal;
  assign illegal = !(is_alu || is_jnc || is_jmp);
`endif

  // Next-state logic: fetch sequencing and architectural updates at EXEC end
  always_comb begin
    state_d   = state_q;
    fcnt_d    = fcnt_q;
    pc_d      = pc_q;
    carry_d   = carry_q;
    ir_d      = ir_q;
    retired_d = retired_q;
    case (state_q)
      StHalt: begin
        // busy is 0 here, so this is the only place step is honoured
        if (bus.run || bus.step) begin
          state_d = StFetch;
          fcnt_d  = '0;
        end
      end
      StFetch: begin
        if (fcnt_q == FetchLast) begin
          ir_d    = bus.instr;
          state_d = StExec;
        end else begin
          fcnt_d = fcnt_q + FetchW'(1);
        end
      end
      StExec: begin
        retired_d = retired_q + CNT_W'(1);
        pc_d      = pc_q + 4'd1;
        // Jumps and undefined opcodes clear carry; JNC tests the old value
        carry_d   = is_alu ? bus.alu_cout : 1'b0;
        if (is_jmp || (is_jnc && !carry_q)) begin
          pc_d = ir_q[3:0];
        end
        fcnt_d  = '0;
        state_d = bus.run ? StFetch : StHalt;
`ifdef TD4_ILLEGAL_HALT_EN
        if (illegal) begin
          pc_d      = pc_q;
          carry_d   = carry_q;
          retired_d = retired_q;
          state_d   = StTrap;
        end
`endif
      end
`ifdef TD4_ILLEGAL_HALT_EN
      StTrap: state_d = StTrap;  // only rst leaves
`endif
      default: state_d = StHalt;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StHalt;
      fcnt_q    <= '0;
      pc_q      <= 4'd0;
      carry_q   <= 1'b0;
      ir_q      <= 8'h00;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      fcnt_q    <= fcnt_d;
      pc_q      <= pc_d;
      carry_q   <= carry_d;
      ir_q      <= ir_d;
      retired_q <= retired_d;
    end
  end

  // Load strobes: only in EXEC, and never in a reset cycle
  always_comb begin
    ld = 3'b000;
    if ((state_q == StExec) && !rst) begin
      ld = dec_ld;
    end
  end

  assign bus.ld_a    = ld[2];
  assign bus.ld_b    = ld[1];
  assign bus.ld_out  = ld[0];
  assign bus.sel     = dec_sel;
  assign bus.imm     = ir_q[3:0];
  assign bus.pc      = pc_q;
  assign bus.carry   = carry_q;
  assign bus.busy    = (state_q == StFetch) || (state_q == StExec);
  assign bus.retired = retired_q;
`ifdef TD4_ILLEGAL_HALT_EN
  assign bus.trap    = (state_q == StTrap);
`endif

endmodule

// File: tb/tb_td4_seq.sv
// Self-checking bench for td4_seq (ROM_LAT=1, combinational ROM model).
// Expected strobes and retirements are queued as stimulus is set up and
// popped by a monitor when the DUT produces them.
module tb_td4_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  td4_seq_if #(.CNT_W(8)) bus ();

  td4_seq #(.ROM_LAT(1), .CNT_W(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [7:0] rom [16];
  logic       cout_drv;
  logic       cout_alt;

  assign bus.instr    = rom[bus.pc];
  assign bus.alu_cout = cout_drv ^ (cout_alt & bus.pc[0]);

  typedef struct packed {
    logic [2:0] mask;  // {ld_a, ld_b, ld_out}
    logic [1:0] sel;
    logic [3:0] imm;
  } strobe_t;

  typedef struct packed {
    logic [3:0] pc;
    logic       carry;
    logic [7:0] retired;
  } retire_t;

  strobe_t strobe_q[$];
  retire_t retire_q[$];
  int n_cmp = 0;
  int n_err = 0;

  function automatic strobe_t exp_strobe(input logic [7:0] ins);
    strobe_t s;
    s.imm  = ins[3:0];
    s.sel  = 2'b11;
    s.mask = 3'b000;
    case (ins[7:4])
      4'h0: begin s.mask = 3'b100; s.sel = 2'b00; end
      4'h1: begin s.mask = 3'b100; s.sel = 2'b01; end
      4'h2: begin s.mask = 3'b100; s.sel = 2'b10; end
      4'h3: begin s.mask = 3'b100; s.sel = 2'b11; end
      4'h4: begin s.mask = 3'b010; s.sel = 2'b00; end
      4'h5: begin s.mask = 3'b010; s.sel = 2'b01; end
      4'h6: begin s.mask = 3'b010; s.sel = 2'b10; end
      4'h7: begin s.mask = 3'b010; s.sel = 2'b11; end
      4'h9: begin s.mask = 3'b001; s.sel = 2'b01; end
      4'hB: begin s.mask = 3'b001; s.sel = 2'b11; end
      default: ;
    endcase
    return s;
  endfunction

  // Monitor: pops expectations whenever a strobe fires or retired moves
  initial begin
    logic [7:0] prev_ret;
    logic       rst_last;
    strobe_t    s;
    retire_t    r;
    rst_last = 1'b1;
    prev_ret = '0;
    forever begin
      @(negedge clk);
      if (!rst_last && (bus.retired !== prev_ret)) begin
        n_cmp++;
        if (retire_q.size() == 0) begin
          n_err++;
          $display("FAIL retire_unexpected: got pc=%0d carry=%b retired=%0d, want none",
                   bus.pc, bus.carry, bus.retired);
        end else begin
          r = retire_q.pop_front();
          if ({bus.pc, bus.carry, bus.retired} !== r) begin
            n_err++;
            $display("FAIL retire: got pc=%0d carry=%b retired=%0d, want pc=%0d carry=%b retired=%0d",
                     bus.pc, bus.carry, bus.retired, r.pc, r.carry, r.retired);
          end
        end
      end
      if ({bus.ld_a, bus.ld_b, bus.ld_out} !== 3'b000) begin
        n_cmp++;
        if (strobe_q.size() == 0) begin
          n_err++;
          $display("FAIL strobe_unexpected: got ld=%b at pc=%0d, want none",
                   {bus.ld_a, bus.ld_b, bus.ld_out}, bus.pc);
        end else begin
          s = strobe_q.pop_front();
          if ({bus.ld_a, bus.ld_b, bus.ld_out, bus.sel, bus.imm} !== s) begin
            n_err++;
            $display("FAIL strobe: got ld=%b sel=%b imm=%h, want ld=%b sel=%b imm=%h",
                     {bus.ld_a, bus.ld_b, bus.ld_out}, bus.sel, bus.imm, s.mask, s.sel, s.imm);
          end
        end
      end
      prev_ret = bus.retired;
      rst_last = rst;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_strobe(input logic [7:0] ins);
    strobe_q.push_back(exp_strobe(ins));
  endtask

  task automatic push_retire(input logic [3:0] p, input logic c, input logic [7:0] n);
    retire_t r;
    r.pc      = p;
    r.carry   = c;
    r.retired = n;
    retire_q.push_back(r);
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    bus.run  = 1'b0;
    bus.step = 1'b0;
    cout_drv = 1'b0;
    cout_alt = 1'b0;
    for (int i = 0; i < 16; i++) rom[i] = 8'h00;
    tick();
    tick();
    strobe_q.delete();
    retire_q.delete();
    rst = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int i;
    for (i = 0; i < 40; i++) begin
      if (bus.busy === 1'b0) break;
      tick();
    end
    n_cmp++;
    if (i == 40) begin
      n_err++;
      $display("FAIL %s_idle_timeout: got busy=%b after 40 cycles, want 0", name, bus.busy);
    end
  endtask

  task automatic check_drained(input string name);
    tick();
    n_cmp++;
    if ((strobe_q.size() != 0) || (retire_q.size() != 0)) begin
      n_err++;
      $display("FAIL %s_drain: got %0d strobes / %0d retires outstanding, want 0 / 0",
               name, strobe_q.size(), retire_q.size());
    end
    strobe_q.delete();
    retire_q.delete();
  endtask

  // Run for exactly n back-to-back instructions (2 cycles each), then halt
  task automatic run_instrs(input int n, input string name);
    bus.run = 1'b1;
    repeat (2 * n - 1) tick();
    bus.run = 1'b0;
    wait_idle(name);
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({bus.pc, bus.carry, bus.retired} !== 13'd0) begin
      n_err++;
      $display("FAIL reset_state: got pc=%0d carry=%b retired=%0d, want 0/0/0",
               bus.pc, bus.carry, bus.retired);
    end
    n_cmp++;
    if ({bus.busy, bus.ld_a, bus.ld_b, bus.ld_out} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_ctrl: got busy,ld=%b, want 0000",
               {bus.busy, bus.ld_a, bus.ld_b, bus.ld_out});
    end
`ifdef TD4_ILLEGAL_HALT_EN
    n_cmp++;
    if (bus.trap !== 1'b0) begin
      n_err++;
      $display("FAIL reset_trap: got %b, want 0", bus.trap);
    end
`endif
  endtask

  task automatic test_run_basic();
    do_reset();
    rom[0] = 8'h35;
    push_strobe(8'h35);
    push_retire(4'd1, 1'b0, 8'd1);
    bus.run = 1'b1;
    tick();
    bus.run = 1'b0;
    n_cmp++;
    if ({bus.busy, bus.ld_a, bus.ld_b, bus.ld_out} !== 4'b1000) begin
      n_err++;
      $display("FAIL basic_fetch: got busy,ld=%b, want 1000",
               {bus.busy, bus.ld_a, bus.ld_b, bus.ld_out});
    end
    tick();
    n_cmp++;
    if ({bus.ld_a, bus.ld_b, bus.ld_out, bus.sel, bus.imm} !== {3'b100, 2'b11, 4'h5}) begin
      n_err++;
      $display("FAIL basic_exec: got ld=%b sel=%b imm=%h, want 100/11/5",
               {bus.ld_a, bus.ld_b, bus.ld_out}, bus.sel, bus.imm);
    end
    tick();
    n_cmp++;
    if ({bus.busy, bus.pc, bus.retired} !== {1'b0, 4'd1, 8'd1}) begin
      n_err++;
      $display("FAIL basic_after: got busy=%b pc=%0d retired=%0d, want 0/1/1",
               bus.busy, bus.pc, bus.retired);
    end
    check_drained("basic");
  endtask

  task automatic test_jnc();
    // carry set by the ADD: JNC falls through and clears carry
    do_reset();
    rom[0] = 8'h0F;
    rom[1] = 8'hE7;
    cout_drv = 1'b1;
    push_strobe(8'h0F);
    push_retire(4'd1, 1'b1, 8'd1);
    push_retire(4'd2, 1'b0, 8'd2);
    run_instrs(2, "jnc_fall");
    check_drained("jnc_fall");
    // carry clear: JNC is taken
    do_reset();
    rom[0] = 8'h0F;
    rom[1] = 8'hE7;
    push_strobe(8'h0F);
    push_retire(4'd1, 1'b0, 8'd1);
    push_retire(4'd7, 1'b0, 8'd2);
    run_instrs(2, "jnc_taken");
    check_drained("jnc_taken");
    n_cmp++;
    if (bus.pc !== 4'd7) begin
      n_err++;
      $display("FAIL jnc_taken_pc: got %0d, want 7", bus.pc);
    end
  endtask

  task automatic test_wrap_jmp();
    do_reset();
    rom[0]  = 8'hFF;
    rom[15] = 8'h33;
    cout_drv = 1'b1;
    push_retire(4'd15, 1'b0, 8'd1);
    push_strobe(8'h33);
    push_retire(4'd0, 1'b1, 8'd2);
    run_instrs(2, "wrap");
    check_drained("wrap");
    do_reset();
    rom[0] = 8'h52;
    rom[1] = 8'hF0;
    cout_drv = 1'b1;
    push_strobe(8'h52);
    push_retire(4'd1, 1'b1, 8'd1);
    push_retire(4'd0, 1'b0, 8'd2);
    run_instrs(2, "jmp0");
    check_drained("jmp0");
  endtask

  task automatic test_back_to_back();
    logic [7:0] prog [10] = '{8'h01, 8'h12, 8'h23, 8'h34, 8'h45,
                              8'h56, 8'h67, 8'h78, 8'h99, 8'hBA};
    logic [3:0] k4;
    do_reset();
    cout_alt = 1'b1;  // alu_cout follows pc[0]
    for (int k = 0; k < 10; k++) begin
      rom[k] = prog[k];
      k4 = 4'(k);
      push_strobe(prog[k]);
      push_retire(4'(k + 1), k4[0], 8'(k + 1));
    end
    run_instrs(10, "b2b");
    check_drained("b2b");
  endtask

  task automatic test_step();
    do_reset();
    rom[0] = 8'h71;
    push_strobe(8'h71);
    push_retire(4'd1, 1'b0, 8'd1);
    bus.step = 1'b1;
    tick();
    bus.step = 1'b0;
    n_cmp++;
    if (bus.busy !== 1'b1) begin
      n_err++;
      $display("FAIL step_busy1: got %b, want 1", bus.busy);
    end
    tick();
    bus.step = 1'b1;  // lands during EXEC, must be dropped
    n_cmp++;
    if ({bus.busy, bus.ld_b} !== 2'b11) begin
      n_err++;
      $display("FAIL step_busy2: got busy,ld_b=%b, want 11", {bus.busy, bus.ld_b});
    end
    tick();
    bus.step = 1'b0;
    repeat (4) tick();
    n_cmp++;
    if ({bus.busy, bus.pc, bus.retired} !== {1'b0, 4'd1, 8'd1}) begin
      n_err++;
      $display("FAIL step_ignored: got busy=%b pc=%0d retired=%0d, want 0/1/1",
               bus.busy, bus.pc, bus.retired);
    end
    check_drained("step");
  endtask

  task automatic test_reset_exec();
    do_reset();
    rom[0] = 8'h0F;
    rom[1] = 8'h93;
    cout_drv = 1'b1;
    push_strobe(8'h0F);
    push_retire(4'd1, 1'b1, 8'd1);
    run_instrs(1, "rexec_pre");
    check_drained("rexec_pre");
    bus.run = 1'b1;
    tick();
    tick();  // now in EXEC of OUT B
    rst = 1'b1;
    bus.run = 1'b0;
    #1;
    n_cmp++;
    if (bus.ld_out !== 1'b0) begin
      n_err++;
      $display("FAIL rexec_ld_out: got %b, want 0", bus.ld_out);
    end
    tick();
    rst = 1'b0;
    n_cmp++;
    if ({bus.busy, bus.pc, bus.carry, bus.retired} !== 14'd0) begin
      n_err++;
      $display("FAIL rexec_state: got busy=%b pc=%0d carry=%b retired=%0d, want all 0",
               bus.busy, bus.pc, bus.carry, bus.retired);
    end
    tick();
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL rexec_halt: got busy=%b, want 0", bus.busy);
    end
    check_drained("rexec");
  endtask

  task automatic test_illegal();
    do_reset();
    rom[0] = 8'h0F;
    rom[1] = 8'h80;
    rom[2] = 8'h35;
    cout_drv = 1'b1;
    push_strobe(8'h0F);
    push_retire(4'd1, 1'b1, 8'd1);
`ifdef TD4_ILLEGAL_HALT_EN
    bus.run = 1'b1;
    repeat (5) tick();
    n_cmp++;
    if ({bus.trap, bus.busy, bus.pc, bus.carry, bus.retired} !== {2'b10, 4'd1, 1'b1, 8'd1}) begin
      n_err++;
      $display("FAIL trap_enter: got trap=%b busy=%b pc=%0d carry=%b retired=%0d",
               bus.trap, bus.busy, bus.pc, bus.carry, bus.retired);
    end
    bus.step = 1'b1;
    tick();
    bus.step = 1'b0;
    repeat (4) tick();
    n_cmp++;
    if ({bus.trap, bus.busy, bus.pc, bus.retired} !== {2'b10, 4'd1, 8'd1}) begin
      n_err++;
      $display("FAIL trap_sticky: got trap=%b busy=%b pc=%0d retired=%0d",
               bus.trap, bus.busy, bus.pc, bus.retired);
    end
    check_drained("trap");
    do_reset();
    n_cmp++;
    if (bus.trap !== 1'b0) begin
      n_err++;
      $display("FAIL trap_clear: got %b, want 0", bus.trap);
    end
`else
    push_retire(4'd2, 1'b0, 8'd2);
    run_instrs(2, "nop");
    check_drained("nop");
    n_cmp++;
    if ({bus.pc, bus.carry} !== {4'd2, 1'b0}) begin
      n_err++;
      $display("FAIL nop_state: got pc=%0d carry=%b, want 2/0", bus.pc, bus.carry);
    end
`endif
  endtask

  initial begin
    rst      = 1'b1;
    bus.run  = 1'b0;
    bus.step = 1'b0;
    cout_drv = 1'b0;
    cout_alt = 1'b0;
    test_reset();
    test_run_basic();
    test_jnc();
    test_wrap_jmp();
    test_back_to_back();
    test_step();
    test_reset_exec();
    test_illegal();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000, want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/td4_seq.md
Name: td4_seq

Overview:
- Instruction sequencer and control unit for the 4-bit TD4 datapath.
- Owns the program counter and carry flag, and fetches 8-bit instructions from the program ROM.
- Decodes each instruction and drives the ALU source-select, immediate and register-load strobes for the A, B and OUT registers.
- Supports free-run and single-step execution so benches and debug can advance the CPU one instruction at a time.

Parameters:
- ROM_LAT, 1, cycles from pc change to valid instr (must be >= 1).
- CNT_W, 8, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- run  in  1  level; 1 = execute continuously.
- step  in  1  one-cycle pulse; executes one instruction while halted.
- instr  in  8  ROM data; [7:4] opcode, [3:0] immediate.
- alu_cout  in  1  carry-out of the datapath adder (src + imm).
- pc  out  4  ROM address / program counter.
- sel  out  2  ALU source: 00=A, 01=B, 10=IN port, 11=zero.
- imm  out  4  immediate, equal to IR[3:0].
- ld_a  out  1  load strobe for register A.
- ld_b  out  1  load strobe for register B.
- ld_out  out  1  load strobe for the OUT register.
- carry  out  1  carry flag.
- busy  out  1  1 while in FETCH or EXEC.
- retired  out  CNT_W  count of executed instructions.

Behaviour:
- Reset (any state): state=HALT, pc=0, carry=0, IR=0x00, retired=0, ld_* = 0. Strobes are gated by rst, so a reset cycle never loads the datapath.
- States:
  - HALT -> FETCH when run=1, or when step=1 in that cycle.
  - FETCH holds pc for ROM_LAT cycles; instr is latched into IR on the last FETCH edge, then -> EXEC.
  - EXEC lasts one cycle; at its closing edge it updates pc, carry and retired, then -> FETCH if run=1, else -> HALT.
- Latency: ROM_LAT+1 cycles per instruction.
- A step pulse is ignored while busy=1 or while run=1. Steps are never queued.
- Deasserting run mid-instruction completes that instruction, then HALT.
- During EXEC, exactly one of the ld_* strobes pulses for one cycle, per opcode. sel/imm are valid throughout EXEC.
- Decode (op: sel, load):
  - 0 ADD A,Im: A, ld_a
  - 1 MOV A,B: B, ld_a
  - 2 IN A: IN, ld_a
  - 3 MOV A,Im: zero, ld_a
  - 4 MOV B,A: A, ld_b
  - 5 ADD B,Im: B, ld_b
  - 6 IN B: IN, ld_b
  - 7 MOV B,Im: zero, ld_b
  - 9 OUT B: B, ld_out
  - B OUT Im: zero, ld_out
- Jumps:
  - E (JNC Im): pc <= Im if carry=0, else pc+1.
  - F (JMP Im): pc <= Im.
  - No strobes are asserted for jumps.
- Carry:
  - ALU-class opcodes: carry <= alu_cout, sampled at the EXEC edge.
  - Jumps: carry <= 0. JNC evaluates the old carry first.
- pc: increments by 1 for non-jumps; 4-bit wrap, 15 -> 0.
- retired: +1 per EXEC; wraps from all-ones to 0.
- Undefined opcodes (8, A, C, D): treated as a NOP. pc+1, carry <= 0, no strobes, retired still increments.

Optional Feature:
- Macro: TD4_ILLEGAL_HALT_EN.
- When defined, an undefined opcode in EXEC makes the block:
  - enter a sticky TRAP state: pc is not advanced, carry and retired are unchanged, no strobes;
  - assert busy=0;
  - ignore run and step until rst.
- Adds output port trap (1 bit), 1 in TRAP, reset 0.
- When not defined: NOP behaviour as above, and no trap port exists.

Test Plan:
- Reset, run=1, ROM[0]=0x35, ROM_LAT=1 -> FETCH, then EXEC one cycle later with ld_a=1, sel=11, imm=5; afterwards pc=1, retired=1; no strobe in any other cycle.
- Program 0x0F then 0xE7 with alu_cout=1 on the ADD -> carry=1, JNC falls through, pc=2, carry=0. Repeat with alu_cout=0 -> pc=7 after JNC.
- pc=15 with instr 0x33 -> pc wraps to 0. Instr 0xF0 anywhere -> pc=0. A jump never pulses ld_*.
- run=0, single step pulse -> busy=1 for 2 cycles, one ld strobe, back in HALT. A second step during busy is ignored (retired +1 only).
- rst asserted during EXEC of 0x9x -> ld_out stays 0 in that cycle; next cycle pc=0, carry=0, retired=0, state HALT.
- instr 0x80, run=1:
  - macro off -> pc+1, carry=0, no strobes.
  - macro on -> trap=1, pc unchanged, held until rst.
